crosshair_overlay: RTL and testbench
====================================

// Module: crosshair_overlay
// PURPOSE
//  Downstream consumer of the centroid calculator. Takes the per-frame centroid and
//  red-object flag, holds them across frames with a miss tolerance, and draws a
//  crosshair marker of fixed colour into the next frame's RGB pixel stream.
//  Output feeds the display/VGA timing stage.
//  2-stage pipeline; no backpressure.
// PARAMETERS
//  IMG_WIDTH       640        active pixels per line
//  IMG_HEIGHT      480        active lines per frame
//  CROSS_HALF_LEN  8          arm length each side of centre, pixels
//  CROSS_THICK     1          arm half-thickness; pixel hit if |d| < CROSS_THICK
//  HOLD_FRAMES     4          consecutive missed frames before track is dropped (>=1)
//  MARK_COLOR      24'hFF0000 RGB888 colour written on marker pixels
// PORTS
//  i_clk               in   1   system clock
//  i_rst               in   1   synchronous reset, active-high
//  i_centroid_x        in   10  centroid x; sampled only when i_eof_valid=1
//  i_centroid_y        in   9   centroid y; sampled only when i_eof_valid=1
//  i_red_object_valid  in   1   object qualified; sampled only when i_eof_valid=1
//  i_eof_valid         in   1   1-cycle strobe: frame result available
//  i_pixel             in   24  RGB888 input pixel, raster order
//  i_px_valid          in   1   i_pixel valid this cycle
//  o_pixel             out  24  RGB888 output pixel
//  o_px_valid          out  1   o_pixel valid; i_px_valid delayed exactly 2 cycles
//  o_marker_active     out  1   1 while the frame being output carries a marker
//  o_track_lost        out  1   1 when miss count has reached HOLD_FRAMES
// BEHAVIOUR
//  Reset: o_pixel=0, o_px_valid=0, o_marker_active=0, o_track_lost=1; raster x/y=0;
//   shadow and active centroid=0; miss_cnt=HOLD_FRAMES; pipeline flushed. Reset
//   mid-frame: next valid pixel is treated as (0,0); no marker until a new valid eof.
//  Raster: own x/y counters advance only on i_px_valid; x wraps at IMG_WIDTH-1, then y++;
//   y wraps at IMG_HEIGHT-1. last_px = i_px_valid && x==W-1 && y==H-1.
//  Track update on i_eof_valid: red_object_valid=1 -> shadow_x/y <= inputs, miss_cnt<=0;
//   else miss_cnt <= min(miss_cnt+1, HOLD_FRAMES). tracked = (miss_cnt < HOLD_FRAMES).
//   o_track_lost = !tracked, registered, updates the cycle after the eof strobe.
//  Frame swap: on last_px, active_x/y/tracked <= shadow values (double buffer).
//   eof strobe in same cycle as last_px: the new eof values bypass into active.
//   Pixels of the current frame never see a mid-frame centroid change.
//  Hit test, stage 1: dx = x - active_x, dy = y - active_y, signed 11-bit.
//   hit = active_tracked && ((|dx|<=CROSS_HALF_LEN && |dy|<CROSS_THICK) ||
//         (|dy|<=CROSS_HALF_LEN && |dx|<CROSS_THICK)).
//   Arms clip at image edges because only in-raster coordinates are tested.
//   No wrap onto the opposite edge.
//  Stage 2: o_pixel <= hit ? MARK_COLOR : pixel from stage 1; o_px_valid <= stage-1 valid.
//   Latency exactly 2 cycles. Gaps in i_px_valid propagate unchanged.
//   o_pixel holds its last value when invalid.
//  o_marker_active <= active_tracked; updates with the swap, seen 1 cycle after last_px.
// CONFIGURATION
//  OVERLAY_HOLD_BLINK_EN defined: during hold (tracked && miss_cnt>0), marker drawn
//   only on frames where a 1-bit frame toggle (flips on last_px, reset 0) is 0.
//   o_marker_active then follows the gated value.
//  Not defined: marker drawn solid on every frame while tracked; no toggle register.
// TESTING
//  eof(x=320,y=240,valid=1), then frame of 24'h808080: row 240 x=312..328 and col 320
//   y=232..248 = FF0000, all else 808080; o_px_valid = i_px_valid delayed 2 cycles.
//  eof(x=2,y=1,valid=1): marks at x=0..10 row 1 and y=0..9 col 2 only.
//   Row 0 / x=636..639 and row 479 unmarked.
//  Valid eof then 4 eofs with valid=0: marker present in next 3 frames,
//   absent in 4th-eof frame onward; o_track_lost=1 the cycle after 4th eof.
//  eof(valid, 100,100) coincident with last_px: the very next frame shows marker at (100,100).
//  i_rst asserted at pixel (100,50): o_px_valid=0 two cycles later and stays 0 until input resumes.
//   Restart frame unmarked; o_track_lost=1.
//  Random i_px_valid gaps (~30%): output stream equals golden model delayed 2 valid-aligned cycles;
//   with OVERLAY_HOLD_BLINK_EN, during hold the marker appears on alternate frames.

Source files
------------

// File: rtl/crosshair_overlay.sv
// Draws a fixed-colour crosshair at the tracked centroid into a raster RGB888 stream (2-cycle latency).
// Optional OVERLAY_HOLD_BLINK_EN: the marker blinks on alternate frames while the track is in hold.
module crosshair_overlay #(
  parameter int          IMG_WIDTH      = 640,
  parameter int          IMG_HEIGHT     = 480,
  parameter int          CROSS_HALF_LEN = 8,
  parameter int          CROSS_THICK    = 1,
  parameter int          HOLD_FRAMES    = 4,
  parameter logic [23:0] MARK_COLOR     = 24'hFF0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_centroid_x,
  input  logic [8:0]  i_centroid_y,
  input  logic        i_red_object_valid,
  input  logic        i_eof_valid,
  input  logic [23:0] i_pixel,
  input  logic        i_px_valid,
  output logic [23:0] o_pixel,
  output logic        o_px_valid,
  output logic        o_marker_active,
  output logic        o_track_lost
);

  localparam int          MW       = $clog2(HOLD_FRAMES + 1);
  localparam logic [9:0]  X_LAST   = 10'(IMG_WIDTH - 1);
  localparam logic [8:0]  Y_LAST   = 9'(IMG_HEIGHT - 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(HOLD_FRAMES);
  localparam logic [10:0] HALF_LEN = 11'(CROSS_HALF_LEN);
  localparam logic [10:0] THICK    = 11'(CROSS_THICK);

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  logic [9:0]    raster_x;
  logic [8:0]    raster_y;
  logic          last_px;

  logic [9:0]    shadow_x, shadow_x_next;
  logic [8:0]    shadow_y, shadow_y_next;
  logic [MW-1:0] miss_cnt, miss_next;
  logic          tracked_next;
  logic          draw_next;

  logic [9:0]    active_x;
  logic [8:0]    active_y;
  logic          active_draw;

  logic signed [10:0] dx, dy;
  logic [10:0]   adx, ady;
  logic          hit;

  logic [23:0]   s1_pixel;
  logic          s1_valid;
  logic          s1_hit;

  assign last_px = i_px_valid && (raster_x == X_LAST) && (raster_y == Y_LAST);

  // Raster position of the pixel currently on i_pixel.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      raster_x <= '0;
      raster_y <= '0;
    end else if (i_px_valid) begin
      if (raster_x == X_LAST) begin
        raster_x <= '0;
        raster_y <= (raster_y == Y_LAST) ? 9'd0 : raster_y + 1'b1;
      end else begin
        raster_x <= raster_x + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    shadow_x_next = shadow_x;
    shadow_y_next = shadow_y;
    miss_next     = miss_cnt;
    if (i_eof_valid) begin
      if (i_red_object_valid) begin
        shadow_x_next = i_centroid_x;
        shadow_y_next = i_centroid_y;
        miss_next     = '0;
      end else if (miss_cnt != MISS_MAX) begin
        miss_next = miss_cnt + 1'b1;
      end
    end
  end

  assign tracked_next = (miss_next < MISS_MAX);

`ifdef OVERLAY_HOLD_BLINK_EN
  logic blink_toggle;

  // Post-flip toggle value is the one that applies to the frame being swapped in.
  assign draw_next = tracked_next && !((miss_next != '0) && !blink_toggle);

  always_ff @(posedge i_clk) begin
    if (i_rst)        blink_toggle <= 1'b0;
    else if (last_px) blink_toggle <= ~blink_toggle;
  end
`else
  assign draw_next = tracked_next;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      miss_cnt     <= MISS_MAX;
      o_track_lost <= 1'b1;
    end else begin
      shadow_x     <= shadow_x_next;
      shadow_y     <= shadow_y_next;
      miss_cnt     <= miss_next;
      o_track_lost <= !tracked_next;
    end
  end

  // Double buffer: the next frame takes the shadow (with same-cycle eof bypass) only at last_px.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_x    <= '0;
      active_y    <= '0;
      active_draw <= 1'b0;
    end else if (last_px) begin
      active_x    <= shadow_x_next;
      active_y    <= shadow_y_next;
      active_draw <= draw_next;
    end
  end

  assign o_marker_active = active_draw;

  // Only in-raster coordinates are tested, so arms clip at the edges and never wrap.
  assign dx  = $signed({1'b0, raster_x}) - $signed({1'b0, active_x});
  assign dy  = $signed({2'b0, raster_y}) - $signed({2'b0, active_y});
  assign adx = abs11(dx);
  assign ady = abs11(dy);
  assign hit = active_draw &&
               (((adx <= HALF_LEN) && (ady < THICK)) ||
                ((ady <= HALF_LEN) && (adx < THICK)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_pixel <= '0;
      s1_hit   <= 1'b0;
    end else begin
      s1_valid <= i_px_valid;
      if (i_px_valid) begin
        s1_pixel <= i_pixel;
        s1_hit   <= hit;
      end
    end
  end

  // o_pixel holds its last value across gaps in the stream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_px_valid <= 1'b0;
      o_pixel    <= '0;
    end else begin
      o_px_valid <= s1_valid;
      if (s1_valid) o_pixel <= s1_hit ? MARK_COLOR : s1_pixel;
    end
  end

endmodule

// File: tb/tb_crosshair_overlay.sv
// Bench for crosshair_overlay on a reduced 40x30 raster: frame-level model, probe table, corner sequences.
module tb_crosshair_overlay;

  localparam int          W     = 40;
  localparam int          H     = 30;
  localparam int          NPX   = W * H;
  localparam int          HALF  = 8;
  localparam int          THICK = 1;
  localparam int          HOLD  = 4;
  localparam logic [23:0] MARK  = 24'hFF0000;
  localparam logic [23:0] GRAY  = 24'h808080;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic        red;
  logic        eof;
  logic [23:0] pix;
  logic        pv;
  logic [23:0] o_pixel;
  logic        o_px_valid;
  logic        o_marker_active;
  logic        o_track_lost;

  always #5 clk = ~clk;

  crosshair_overlay #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CROSS_HALF_LEN(HALF), .CROSS_THICK(THICK),
    .HOLD_FRAMES(HOLD), .MARK_COLOR(MARK)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_centroid_x(cx), .i_centroid_y(cy),
    .i_red_object_valid(red), .i_eof_valid(eof), .i_pixel(pix), .i_px_valid(pv),
    .o_pixel(o_pixel), .o_px_valid(o_px_valid), .o_marker_active(o_marker_active),
    .o_track_lost(o_track_lost)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: frame-level track, double-buffered display state, 2-deep output delay.
  int          m_x, m_y, m_sx, m_sy, m_miss, m_ax, m_ay;
  bit          m_draw, m_tog;
  bit          p1_v, exp_v;
  logic [23:0] p1_pix, hold_pix;

  logic [23:0] cap [H][W];
  int          ox, oy;
  logic        prev_lost, last_lost;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit model_hit(input int px, input int py);
    int ddx, ddy;
    ddx = iabs(px - m_ax);
    ddy = iabs(py - m_ay);
    return m_draw && ((ddx <= HALF && ddy < THICK) || (ddy <= HALF && ddx < THICK));
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_miss = HOLD; m_ax = 0; m_ay = 0;
    m_draw = 0; m_tog = 0; p1_v = 0; exp_v = 0; p1_pix = '0; hold_pix = '0;
  endtask

  function automatic int count_marks();
    int n = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (cap[yy][xx] === MARK) n++;
    return n;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [23:0] p,
                       input bit e, input bit rd, input int ex, input int ey);
    bit          last;
    logic [23:0] np;
    rst = r; pv = v; pix = p; eof = e; red = rd; cx = 10'(ex); cy = 9'(ey);
    if (r) begin
      model_reset();
    end else begin
      exp_v = p1_v;
      if (p1_v) hold_pix = p1_pix;
      np   = model_hit(m_x, m_y) ? MARK : p;
      last = v && (m_x == W - 1) && (m_y == H - 1);
      if (e) begin
        if (rd) begin m_sx = ex; m_sy = ey; m_miss = 0; end
        else if (m_miss < HOLD) m_miss++;
      end
      if (last) begin
        m_ax = m_sx; m_ay = m_sy; m_tog = !m_tog;
        m_draw = (m_miss < HOLD);
`ifdef OVERLAY_HOLD_BLINK_EN
        if (m_miss > 0 && m_tog) m_draw = 0;
`endif
      end
      if (v) begin
        if (m_x == W - 1) begin m_x = 0; m_y = (m_y == H - 1) ? 0 : m_y + 1; end
        else m_x++;
      end
      p1_v = v; p1_pix = np;
    end
    @(posedge clk); #1;
    check("stream", {7'b0, o_px_valid, o_pixel}, {7'b0, exp_v, hold_pix});
    check("flags", {30'b0, o_marker_active, o_track_lost}, {30'b0, m_draw, m_miss >= HOLD});
    if (r) begin
      ox = 0; oy = 0;
    end else if (o_px_valid) begin
      cap[oy][ox] = o_pixel;
      if (ox == W - 1) begin ox = 0; oy = (oy == H - 1) ? 0 : oy + 1; end
      else ox++;
    end
  endtask

  task automatic drive_px(input logic [23:0] p, input bit e, input bit rd,
                          input int ex, input int ey, input int gap);
    int n = 0;
    while (gap > 0 && n < 6 && $urandom_range(99) < gap) begin
      cycle(0, 0, '0, 0, 0, 0, 0);
      n++;
    end
    cycle(0, 1, p, e, rd, ex, ey);
  endtask

  task automatic run_frame(input int eof_idx, input bit rd, input int ex, input int ey,
                           input bit rnd, input int gap);
    logic [23:0] p;
    for (int i = 0; i < NPX; i++) begin
      p = rnd ? 24'($urandom) : GRAY;
      if (i == NPX - 1) prev_lost = o_track_lost;
      drive_px(p, i == eof_idx, rd, ex, ey, gap);
      if (i == NPX - 1) last_lost = o_track_lost;
    end
    cycle(0, 0, '0, 0, 0, 0, 0);
    cycle(0, 0, '0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int cx; int cy; int px; int py; bit mark;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int eidx;
    bit rd;
    tbl.push_back('{20, 15, 20, 15, 1});
    tbl.push_back('{20, 15, 12, 15, 1});
    tbl.push_back('{20, 15, 11, 15, 0});
    tbl.push_back('{20, 15, 28, 15, 1});
    tbl.push_back('{20, 15, 29, 15, 0});
    tbl.push_back('{20, 15, 20,  7, 1});
    tbl.push_back('{20, 15, 20, 23, 1});
    tbl.push_back('{20, 15, 20, 24, 0});
    tbl.push_back('{20, 15, 21, 16, 0});
    tbl.push_back('{ 2,  1,  0,  1, 1});
    tbl.push_back('{ 2,  1, 10,  1, 1});
    tbl.push_back('{ 2,  1,  2,  0, 1});
    tbl.push_back('{ 2,  1,  2,  9, 1});
    tbl.push_back('{ 2,  1,  2, 10, 0});
    tbl.push_back('{ 2,  1, 39,  0, 0});
    tbl.push_back('{ 2,  1,  2, 29, 0});
    tbl.push_back('{38, 28, 39, 28, 1});
    tbl.push_back('{38, 28,  0, 29, 0});
    tbl.push_back('{38, 28, 38, 20, 1});
    tbl.push_back('{38, 28, 38, 29, 1});
    tbl.push_back('{ 0,  0, 39, 29, 0});

    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        cap[yy][xx] = '0;
    model_reset();
    ox = 0; oy = 0;
    prev_lost = 0; last_lost = 0;

    repeat (3) cycle(1, 0, '0, 0, 0, 0, 0);
    check("rst_px_valid", o_px_valid, 0);
    check("rst_pixel", o_pixel, 0);
    check("rst_track_lost", o_track_lost, 1);
    check("rst_marker", o_marker_active, 0);

    // Each frame carries the next row's eof while displaying the previous row's centroid.
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) run_frame(0, 1, tbl[i].cx, tbl[i].cy, 0, 0);
      else                run_frame(-1, 0, 0, 0, 0, 0);
      if (i > 0)
        check($sformatf("tbl%0d_(%0d,%0d)", i - 1, tbl[i-1].px, tbl[i-1].py),
              {8'b0, cap[tbl[i-1].py][tbl[i-1].px]}, {8'b0, tbl[i-1].mark ? MARK : GRAY});
    end

    // Hold: valid eof, then four misses, each coincident with last_px.
    run_frame(NPX - 1, 1, 20, 15, 0, 0);
    check("hold_arm_lost", last_lost, 0);
    check("hold_arm_marker", o_marker_active, 1);
    for (int k = 1; k <= 4; k++) begin
      run_frame(NPX - 1, 0, 0, 0, 0, 0);
      check($sformatf("hold%0d_lost_before", k), prev_lost, 0);
      check($sformatf("hold%0d_lost_after", k), last_lost, (k == 4) ? 1 : 0);
`ifndef OVERLAY_HOLD_BLINK_EN
      check($sformatf("hold%0d_marker", k), o_marker_active, (k < 4) ? 1 : 0);
`endif
    end

    // Eof bypass at last_px: the very next frame carries the marker.
    run_frame(NPX - 1, 1, 20, 10, 0, 0);
    check("bypass_prev_unmarked", count_marks(), 0);
    run_frame(-1, 0, 0, 0, 0, 0);
    check("bypass_center", cap[10][20], MARK);
    check("bypass_left_tip", cap[10][12], MARK);
    check("bypass_top_tip", cap[2][20], MARK);
    check("bypass_past_right", cap[10][29], GRAY);
    check("bypass_count", count_marks(), 33);

    // Reset at pixel (10,5) while a marker is showing.
    for (int i = 0; i < 5 * W + 10; i++) drive_px(GRAY, 0, 0, 0, 0, 0);
    cycle(1, 1, GRAY, 0, 0, 0, 0);
    check("rst_mid_valid_0", o_px_valid, 0);
    cycle(0, 0, '0, 0, 0, 0, 0);
    check("rst_mid_valid_1", o_px_valid, 0);
    cycle(0, 0, '0, 0, 0, 0, 0);
    check("rst_mid_valid_2", o_px_valid, 0);
    run_frame(-1, 0, 0, 0, 0, 0);
    check("restart_unmarked", count_marks(), 0);
    check("restart_lost", o_track_lost, 1);
    check("restart_marker", o_marker_active, 0);

    // Random pixels, ~30% gaps, random eof placement and object validity.
    repeat (6) begin
      eidx = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(NPX - 1));
      if ($urandom_range(4) == 0) eidx = NPX - 1;
      rd = bit'($urandom_range(1));
      run_frame(eidx, rd, int'($urandom_range(W - 1)), int'($urandom_range(H - 1)), 1, 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
